pll_lock_ctrl: RTL and testbench
================================

# pll_lock_ctrl

Digital calibration and lock controller for the PLL phase/frequency detector path. It runs in one system clock domain and synchronizes the PFD `up`/`dn` pulses. It sequences a successive-approximation (SAR) search of the VCO coarse band with the charge pump disabled, then enables the charge pump. It then qualifies lock over consecutive measurement windows and asserts `locked`. If lock is lost persistently, it restarts calibration automatically.

## Interface
- `BAND_W`, 4, width of VCO coarse band code.
- `WIN`, 256, clk cycles per measurement window (≥2).
- `SETTLE`, 64, clk cycles of settling wait before a window (≥1).
- `MARGIN`, 8, count difference required to declare VCO fast during calibration.
- `LOCK_THR`, 4, maximum `up` count and maximum `dn` count for a "good" tracking window.
- `LOCK_N`, 4, consecutive good windows needed to assert `locked`.
- `UNLOCK_N`, 2, consecutive bad windows while locked that force recalibration.

Ports:
- `clk`  in  1  system sampling clock; rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request calibration; level sampled per edge; honoured only in IDLE.
- `up`  in  1  PFD up output; asynchronous to `clk`.
- `dn`  in  1  PFD dn output; asynchronous to `clk`.
- `band`  out  BAND_W  VCO coarse band code.
- `cp_en`  out  1  charge-pump enable.
- `busy`  out  1  high in every state except IDLE.
- `cal_done`  out  1  high once the SAR search has completed.
- `locked`  out  1  lock indication.

## Operation
- **Synchronizers.** `up` and `dn` each pass through a 2-flop synchronizer (`up_s`, `dn_s`).
- **Counters.** `up_cnt` and `dn_cnt` are each `$clog2(WIN+1)` bits wide and cannot overflow. Both clear on entry to any measure state.
- **States.** IDLE, SETTLE, CAL_MEAS, TRK_MEAS.
  - **IDLE.** If `start`=1 at an edge, the same edge loads:
    - `band` = 1<<(BAND_W-1), `bit` = BAND_W-1;
    - `cp_en` = 0, `cal_done` = 0, `locked` = 0;
    - next state SETTLE.
  - **SETTLE.** Waits SETTLE cycles, then goes to CAL_MEAS if `cal_done`=0, else TRK_MEAS.
  - **CAL_MEAS.** WIN counting edges; the decision uses the final counts at the last edge.
    - "fast" = `dn_cnt` > `up_cnt` + MARGIN. If fast, clear `band[bit]`; otherwise keep it.
    - If `bit`>0: decrement `bit`, set the new `band[bit]`, next state SETTLE.
    - If `bit`=0: set `cal_done`=1 and `cp_en`=1, next state SETTLE (loop settle).
  - **TRK_MEAS.** WIN counting edges, back-to-back; the next window starts with no settle.
    - "good" = `up_cnt` ≤ LOCK_THR and `dn_cnt` ≤ LOCK_THR.
    - `locked`=0: good increments `good_cnt`; when it reaches LOCK_N, set `locked`=1 and clear `good_cnt`. Bad clears `good_cnt`.
    - `locked`=1: bad increments `bad_cnt`; good clears it. When `bad_cnt` reaches UNLOCK_N, perform the IDLE start load (recalibrate) without returning to IDLE; `busy` stays 1.
- **Start handling.** `start` is ignored outside IDLE. The block never returns to IDLE except via `rst`.
- **Simultaneous samples.** `up_s` and `dn_s` both high in one cycle increment both counters.
- **Reset.** `rst` at any time, including mid-window, immediately forces all state to the reset values below. Counters, `bit`, `good_cnt` and `bad_cnt` also clear.
- **Reset values.** IDLE, `band` = 1<<(BAND_W-1), `cp_en` = 0, `busy` = 0, `cal_done` = 0, `locked` = 0. Synchronizer flops reset to 0.

## Timing
- **Latency.** `up`/`dn` reach the counters after 2 clk edges.
- **Start.** `start` sampled at edge t0 → `busy`=1 from t0.
- **Band updates.** Each `band` update occurs at edge t0 + k·(SETTLE+WIN), for k = 1..BAND_W.
- **End of calibration.** `cal_done`=1 and `cp_en`=1 from edge t0 + BAND_W·(SETTLE+WIN).
- **Earliest lock.** `locked`=1 at edge t0 + BAND_W·(SETTLE+WIN) + SETTLE + LOCK_N·WIN.
- **Loss of lock.** `locked` falls (and `cp_en` falls, `band` resets to mid-scale) at the last edge of the UNLOCK_N-th consecutive bad window.
- **Output timing.** All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: BAND_W=3, WIN=16, SETTLE=4, MARGIN=2, LOCK_THR=1, LOCK_N=2, UNLOCK_N=2.

1. **Reset.** `rst` high, then released → `band`=3'b100, `cp_en`=`busy`=`cal_done`=`locked`=0. Re-asserting `rst` at t0+30 mid-calibration returns these values immediately, asynchronously.
2. **VCO fast.** `dn`=1, `up`=0 throughout calibration → `band` 100→010→001→000 at t0+20, 40, 60; `cal_done`=`cp_en`=1 at t0+60.
3. **VCO slow.** `up`=1, `dn`=0 → `band` 100→110→111→111. Repeat with `up`=`dn`=1 → final `band`=111, since the fast condition is never met.
4. **Lock acquisition.** After scenario 3, `up`=`dn`=0 → `locked`=1 at t0+96. A `start` pulse while `busy` is ignored.
5. **Lock loss.** While locked:
   - One window with `up`=1 followed by a quiet window → `locked` stays 1.
   - Two consecutive windows with `up`=1 → `locked`=0 and `cp_en`=0 at the end of the second window, `band`=100, `busy`=1, recalibration runs.
6. **Metastability / pulse edge cases.**
   - A 1-cycle `up` pulse on the last window edge is not counted in that window.
   - Exactly 3 `dn` counts vs 0 `up` counts → fast (3>2). Exactly 2 vs 0 → not fast.

Source files
------------

// File: rtl/pll_lock_ctrl.sv
// PLL lock controller: SAR search of the VCO coarse band with the charge pump off,
// then windowed qualification of PFD up/dn activity to assert and supervise lock.
module pll_lock_ctrl #(
    parameter int BAND_W   = 4,
    parameter int WIN      = 256,
    parameter int SETTLE   = 64,
    parameter int MARGIN   = 8,
    parameter int LOCK_THR = 4,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              up,
    input  logic              dn,
    output logic [BAND_W-1:0] band,
    output logic              cp_en,
    output logic              busy,
    output logic              cal_done,
    output logic              locked
);

    localparam int CNT_W  = $clog2(WIN + 1);
    localparam int TMR_W  = $clog2(((WIN > SETTLE) ? WIN : SETTLE) + 1);
    localparam int BIT_W  = (BAND_W > 1) ? $clog2(BAND_W) : 1;
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int BAD_W  = $clog2(UNLOCK_N + 1);

    localparam logic [BAND_W-1:0] BAND_MID       = {1'b1, {(BAND_W-1){1'b0}}};
    localparam logic [BIT_W-1:0]  BIT_TOP        = BIT_W'(BAND_W - 1);
    localparam logic [TMR_W-1:0]  TMR_SETTLE_END = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0]  TMR_WIN_END    = TMR_W'(WIN - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAL_MEAS = 2'd2,
        ST_TRK_MEAS = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                up_meta_r, up_s_r, dn_meta_r, dn_s_r;
    logic [CNT_W-1:0]    up_cnt_r, up_cnt_nxt_s, dn_cnt_r, dn_cnt_nxt_s;
    logic [CNT_W-1:0]    up_fin_s, dn_fin_s;
    logic [TMR_W-1:0]    tmr_r, tmr_nxt_s;
    logic [BIT_W-1:0]    bit_r, bit_nxt_s;
    logic [GOOD_W-1:0]   good_cnt_r, good_cnt_nxt_s;
    logic [BAD_W-1:0]    bad_cnt_r, bad_cnt_nxt_s;
    logic [BAND_W-1:0]   band_r, band_nxt_s;
    logic                cp_en_r, cp_en_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                cal_done_r, cal_done_nxt_s;
    logic                locked_r, locked_nxt_s;
    logic                fast_s, good_s, win_end_s, settle_end_s, load_s;

    // Two-flop synchronizers for the PFD pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_meta_r <= 1'b0;
            up_s_r    <= 1'b0;
            dn_meta_r <= 1'b0;
            dn_s_r    <= 1'b0;
        end else begin
            up_meta_r <= up;
            up_s_r    <= up_meta_r;
            dn_meta_r <= dn;
            dn_s_r    <= dn_meta_r;
        end
    end

    // Window-final counts include the sample taken on the closing edge.
    always_comb begin
        up_fin_s     = up_cnt_r + CNT_W'(up_s_r);
        dn_fin_s     = dn_cnt_r + CNT_W'(dn_s_r);
        fast_s       = (32'(dn_fin_s) > (32'(up_fin_s) + 32'(MARGIN)));
        good_s       = (32'(up_fin_s) <= 32'(LOCK_THR)) && (32'(dn_fin_s) <= 32'(LOCK_THR));
        win_end_s    = (tmr_r == TMR_WIN_END);
        settle_end_s = (tmr_r == TMR_SETTLE_END);
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        up_cnt_nxt_s   = up_cnt_r;
        dn_cnt_nxt_s   = dn_cnt_r;
        tmr_nxt_s      = tmr_r;
        bit_nxt_s      = bit_r;
        good_cnt_nxt_s = good_cnt_r;
        bad_cnt_nxt_s  = bad_cnt_r;
        band_nxt_s     = band_r;
        cp_en_nxt_s    = cp_en_r;
        cal_done_nxt_s = cal_done_r;
        locked_nxt_s   = locked_r;
        load_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (settle_end_s) begin
                    tmr_nxt_s    = {TMR_W{1'b0}};
                    up_cnt_nxt_s = {CNT_W{1'b0}};
                    dn_cnt_nxt_s = {CNT_W{1'b0}};
                    state_nxt_s  = cal_done_r ? ST_TRK_MEAS : ST_CAL_MEAS;
                end else begin
                    tmr_nxt_s = tmr_r + TMR_W'(1);
                end
            end
            ST_CAL_MEAS: begin
                if (win_end_s) begin
                    tmr_nxt_s         = {TMR_W{1'b0}};
                    state_nxt_s       = ST_SETTLE;
                    band_nxt_s[bit_r] = band_r[bit_r] & ~fast_s;
                    if (bit_r != {BIT_W{1'b0}}) begin
                        bit_nxt_s                     = bit_r - BIT_W'(1);
                        band_nxt_s[bit_r - BIT_W'(1)] = 1'b1;
                    end else begin
                        cal_done_nxt_s = 1'b1;
                        cp_en_nxt_s    = 1'b1;
                    end
                end else begin
                    tmr_nxt_s    = tmr_r + TMR_W'(1);
                    up_cnt_nxt_s = up_fin_s;
                    dn_cnt_nxt_s = dn_fin_s;
                end
            end
            ST_TRK_MEAS: begin
                if (win_end_s) begin
                    // Tracking windows run back-to-back without a settle gap.
                    tmr_nxt_s    = {TMR_W{1'b0}};
                    up_cnt_nxt_s = {CNT_W{1'b0}};
                    dn_cnt_nxt_s = {CNT_W{1'b0}};
                    if (locked_r) begin
                        if (good_s) begin
                            bad_cnt_nxt_s = {BAD_W{1'b0}};
                        end else if ((32'(bad_cnt_r) + 32'd1) == 32'(UNLOCK_N)) begin
                            load_s = 1'b1;
                        end else begin
                            bad_cnt_nxt_s = bad_cnt_r + BAD_W'(1);
                        end
                    end else begin
                        if (!good_s) begin
                            good_cnt_nxt_s = {GOOD_W{1'b0}};
                        end else if ((32'(good_cnt_r) + 32'd1) == 32'(LOCK_N)) begin
                            locked_nxt_s   = 1'b1;
                            good_cnt_nxt_s = {GOOD_W{1'b0}};
                        end else begin
                            good_cnt_nxt_s = good_cnt_r + GOOD_W'(1);
                        end
                    end
                end else begin
                    tmr_nxt_s    = tmr_r + TMR_W'(1);
                    up_cnt_nxt_s = up_fin_s;
                    dn_cnt_nxt_s = dn_fin_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (load_s) begin
            state_nxt_s    = ST_SETTLE;
            band_nxt_s     = BAND_MID;
            bit_nxt_s      = BIT_TOP;
            cp_en_nxt_s    = 1'b0;
            cal_done_nxt_s = 1'b0;
            locked_nxt_s   = 1'b0;
            busy_nxt_s     = 1'b1;
            tmr_nxt_s      = {TMR_W{1'b0}};
            up_cnt_nxt_s   = {CNT_W{1'b0}};
            dn_cnt_nxt_s   = {CNT_W{1'b0}};
            good_cnt_nxt_s = {GOOD_W{1'b0}};
            bad_cnt_nxt_s  = {BAD_W{1'b0}};
        end else begin
            busy_nxt_s = busy_r;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            up_cnt_r   <= {CNT_W{1'b0}};
            dn_cnt_r   <= {CNT_W{1'b0}};
            tmr_r      <= {TMR_W{1'b0}};
            bit_r      <= {BIT_W{1'b0}};
            good_cnt_r <= {GOOD_W{1'b0}};
            bad_cnt_r  <= {BAD_W{1'b0}};
            band_r     <= BAND_MID;
            cp_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            cal_done_r <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            up_cnt_r   <= up_cnt_nxt_s;
            dn_cnt_r   <= dn_cnt_nxt_s;
            tmr_r      <= tmr_nxt_s;
            bit_r      <= bit_nxt_s;
            good_cnt_r <= good_cnt_nxt_s;
            bad_cnt_r  <= bad_cnt_nxt_s;
            band_r     <= band_nxt_s;
            cp_en_r    <= cp_en_nxt_s;
            busy_r     <= busy_nxt_s;
            cal_done_r <= cal_done_nxt_s;
            locked_r   <= locked_nxt_s;
        end
    end

    assign band     = band_r;
    assign cp_en    = cp_en_r;
    assign busy     = busy_r;
    assign cal_done = cal_done_r;
    assign locked   = locked_r;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: a window-level reference model predicts every output change
// (cycle and value); a negedge monitor pops and compares each change the DUT makes.
`timescale 1ns/1ps
module tb_pll_lock_ctrl;

    localparam int BW = 3;
    localparam int W  = 16;
    localparam int S  = 4;
    localparam int M  = 2;
    localparam int LT = 1;
    localparam int LN = 2;
    localparam int UN = 2;
    localparam int LOGN = 16384;
    localparam logic [6:0] RST_OUTS = 7'b100_0000;

    logic clk = 1'b0;
    logic rst, start, up, dn;
    logic [BW-1:0] band;
    logic cp_en, busy, cal_done, locked;

    pll_lock_ctrl #(.BAND_W(BW), .WIN(W), .SETTLE(S), .MARGIN(M),
                    .LOCK_THR(LT), .LOCK_N(LN), .UNLOCK_N(UN)) dut (
        .clk(clk), .rst(rst), .start(start), .up(up), .dn(dn),
        .band(band), .cp_en(cp_en), .busy(busy), .cal_done(cal_done), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [6:0] outs;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [6:0] mon_prev = RST_OUTS;
    logic [6:0] mon_cur;
    exp_t       mon_e;
    logic [6:0] last_push = RST_OUTS;
    bit         log_up [LOGN];
    bit         log_dn [LOGN];

    // Reference model state, advanced only at window boundaries.
    logic [BW-1:0] m_band = 3'b100;
    logic          m_cp = 1'b0, m_busy = 1'b0, m_cal = 1'b0, m_lock = 1'b0;
    int            m_bit = 0, m_phase = 0, m_t0 = 0, m_k = 0, m_tc = 0, m_good = 0, m_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, expv);
        end
    endtask

    function automatic logic [6:0] m_outs();
        return {m_band, m_cp, m_busy, m_cal, m_lock};
    endfunction

    task automatic model_push(input int c);
        if (m_outs() !== last_push) begin
            exp_q.push_back('{c, m_outs()});
            last_push = m_outs();
        end
    endtask

    // Count of synchronized samples in the window closing at edge e (two-edge lag).
    function automatic int win_sum(input bit is_up, input int e);
        int s = 0;
        for (int i = e - W - 1; i <= e - 2; i++) begin
            if (i >= 0) s += is_up ? int'(log_up[i]) : int'(log_dn[i]);
        end
        return s;
    endfunction

    task automatic model_load(input int c);
        m_band = 3'b100; m_bit = BW - 1; m_cp = 1'b0; m_cal = 1'b0; m_lock = 1'b0;
        m_busy = 1'b1; m_phase = 1; m_t0 = c; m_k = 0; m_good = 0; m_bad = 0;
    endtask

    task automatic model_reset();
        m_band = 3'b100; m_cp = 1'b0; m_busy = 1'b0; m_cal = 1'b0; m_lock = 1'b0;
        m_phase = 0; m_bit = 0; m_good = 0; m_bad = 0;
    endtask

    task automatic model_step(input int c, input logic st);
        int u, d;
        bit good;
        if (m_phase == 0) begin
            if (st) model_load(c);
        end else if (m_phase == 1) begin
            if (c == m_t0 + (m_k + 1) * (S + W)) begin
                u = win_sum(1'b1, c);
                d = win_sum(1'b0, c);
                if (d > u + M) m_band[m_bit] = 1'b0;
                if (m_bit > 0) begin
                    m_bit--;
                    m_band[m_bit] = 1'b1;
                end else begin
                    m_cal = 1'b1; m_cp = 1'b1; m_phase = 2; m_tc = c;
                end
                m_k++;
            end
        end else begin
            if (c > m_tc + S && ((c - m_tc - S) % W) == 0) begin
                u = win_sum(1'b1, c);
                d = win_sum(1'b0, c);
                good = (u <= LT) && (d <= LT);
                if (!m_lock) begin
                    if (good) begin
                        m_good++;
                        if (m_good == LN) begin m_lock = 1'b1; m_good = 0; end
                    end else begin
                        m_good = 0;
                    end
                end else begin
                    if (!good) begin
                        m_bad++;
                        if (m_bad == UN) model_load(c);
                    end else begin
                        m_bad = 0;
                    end
                end
            end
        end
        model_push(c);
    endtask

    task automatic tick(input logic u, input logic d, input logic st);
        up = u; dn = d; start = st;
        @(posedge clk);
        cyc++;
        if (cyc < LOGN) begin log_up[cyc] = u; log_dn[cyc] = d; end
        model_step(cyc, st);
        #1;
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_band"}, 32'(band), 32'(3'b100));
        chk({name, "_cp_en"}, 32'(cp_en), 32'(1'b0));
        chk({name, "_busy"}, 32'(busy), 32'(1'b0));
        chk({name, "_cal_done"}, 32'(cal_done), 32'(1'b0));
        chk({name, "_locked"}, 32'(locked), 32'(1'b0));
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        model_reset();
        model_push(cyc + 1);
        rst = 1'b1; up = 1'b0; dn = 1'b0; start = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        repeat (3) begin
            @(posedge clk);
            cyc++;
            if (cyc < LOGN) begin log_up[cyc] = 1'b0; log_dn[cyc] = 1'b0; end
        end
        #1;
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
    endtask

    function automatic int unsigned pick();
        case ($urandom_range(3))
            0: return 32'd0;
            1: return 32'd0;
            2: return 32'd4;
            default: return 32'd60;
        endcase
    endfunction

    // Output monitor: every observed change must match the next predicted event.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_cur = {band, cp_en, busy, cal_done, locked};
            if (mon_cur !== mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%b expected=%b", cyc, mon_cur, mon_prev);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.outs !== mon_cur) begin
                        failures++;
                        $display("FAIL event got=%b@%0d expected=%b@%0d", mon_cur, cyc, mon_e.outs, mon_e.cyc);
                    end
                end
                mon_prev = mon_cur;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    logic [2:0] fast_seq [1:3];
    logic [2:0] slow_seq [1:3];
    int unsigned pu, pd;
    int t0;

    initial begin
        fast_seq = '{3'b010, 3'b001, 3'b000};
        slow_seq = '{3'b110, 3'b111, 3'b111};
        rst = 1'b1; start = 1'b0; up = 1'b0; dn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        // Reset mid-calibration.
        tick(1'b0, 1'b1, 1'b1);
        chk("start_busy", 32'(busy), 32'(1'b1));
        repeat (29) tick(1'b0, 1'b1, 1'b0);
        do_reset();

        // VCO fast.
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (i % 20 == 0) chk("fast_band", 32'(band), 32'(fast_seq[i / 20]));
            if (i == 59) chk("fast_cal_early", 32'(cal_done), 32'(1'b0));
        end
        chk("fast_cal_done", 32'(cal_done), 32'(1'b1));
        chk("fast_cp_en", 32'(cp_en), 32'(1'b1));
        do_reset();

        // VCO slow.
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (i % 20 == 0) chk("slow_band", 32'(band), 32'(slow_seq[i / 20]));
        end
        do_reset();

        // Both active, then lock acquisition, then lock loss.
        tick(1'b1, 1'b1, 1'b1);
        t0 = cyc;
        for (int i = 1; i <= 60; i++) tick(1'b1, 1'b1, 1'b0);
        chk("both_band", 32'(band), 32'(3'b111));
        for (int i = 61; i <= 96; i++) begin
            tick(1'b0, 1'b0, (i == 80) ? 1'b1 : 1'b0);
            if (i == 95) chk("lock_early", 32'(locked), 32'(1'b0));
        end
        chk("lock_time", 32'(cyc - t0), 32'd96);
        chk("locked", 32'(locked), 32'(1'b1));
        for (int j = 1; j <= 64; j++) begin
            tick(((j <= 12) || (j >= 33)) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (j == 32) chk("lock_hold", 32'(locked), 32'(1'b1));
            if (j == 63) chk("lock_before_loss", 32'(locked), 32'(1'b1));
        end
        chk("loss_locked", 32'(locked), 32'(1'b0));
        chk("loss_cp_en", 32'(cp_en), 32'(1'b0));
        chk("loss_band", 32'(band), 32'(3'b100));
        chk("loss_busy", 32'(busy), 32'(1'b1));
        repeat (80) tick(1'b0, 1'b0, 1'b0);
        do_reset();

        // Pulse-count boundaries: 3 dn vs 0 up is fast, 2 vs 0 is not, last-edge up ignored.
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            tick((i == 20) ? 1'b1 : 1'b0,
                 (i == 5 || i == 8 || i == 11 || i == 25 || i == 30) ? 1'b1 : 1'b0, 1'b0);
            if (i == 20) chk("edge_fast3", 32'(band), 32'(3'b010));
            if (i == 40) chk("edge_notfast2", 32'(band), 32'(3'b011));
        end
        chk("edge_final", 32'(band), 32'(3'b011));

        // Randomized activity levels per window-sized chunk.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            tick(1'b0, 1'b0, 1'b1);
            pu = 0; pd = 0;
            for (int i = 0; i < 300; i++) begin
                if (i % 16 == 0) begin pu = pick(); pd = pick(); end
                tick(($urandom_range(99) < pu) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < pd) ? 1'b1 : 1'b0,
                     ($urandom_range(99) < 5) ? 1'b1 : 1'b0);
            end
        end

        @(negedge clk); #1;
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
